// File: rtl/emu_edge_sched.sv
// -----------------------------------------------------------------------------
// emu_edge_sched
//
// Discrete-event scheduler for the emulator clock generator. It keeps the
// emulated time and the absolute times of the next TX edge, RX rising edge
// and (when pending) RX falling edge. Each clk_sys cycle with run high it
// jumps emulated time to the earliest pending edge and pulses the matching
// clock enables; edges that coincide fire together.
//
// Ordering is done on the unsigned distance (t_x - emu_time) modulo
// 2^TIME_WIDTH. Pending edges are never further than 2^(PERIOD_WIDTH+1)
// ahead of emu_time, so wrap-around of the absolute time is transparent.
//
// Parameters:
//   TIME_WIDTH    width of absolute emulated time (wraps)
//   PERIOD_WIDTH  width of period inputs, PERIOD_WIDTH + 1 < TIME_WIDTH
//
// Ports:
//   clk_sys    in   system clock (ungated)
//   rst        in   synchronous active-high reset, priority over run
//   run        in   advance by one event step per cycle while high
//   tx_period  in   TX edge spacing (0 treated as 1)
//   rx_period  in   RX rising-edge spacing (below 2 treated as 2)
//   rx_jitter  in   signed offset added to rx_period (optional, see below)
//   cke_tx     out  one-cycle TX clock-enable pulse
//   cke_rx_p   out  one-cycle RX rising-edge enable pulse
//   cke_rx_n   out  one-cycle RX falling-edge enable pulse
//   emu_time   out  time of the event signalled by the current enables
//   dt         out  emu_time minus previous emu_time (0 while idle)
//
// All outputs are registered: the enables, emu_time and dt of a step appear
// together one cycle after the run=1 cycle that computed them.
//
// Build option:
//   EMU_EDGE_SCHED_RX_JITTER_EN  adds the signed 8-bit rx_jitter input; the
//   RX period becomes max(rx_period + rx_jitter, 2), sampled with rx_period
//   on each RX rising-edge firing. Requires TIME_WIDTH >= 8.
// -----------------------------------------------------------------------------
module emu_edge_sched #(
    parameter int unsigned TIME_WIDTH   = 32,
    parameter int unsigned PERIOD_WIDTH = 24
) (
    input  logic                    clk_sys,
    input  logic                    rst,
    input  logic                    run,
    input  logic [PERIOD_WIDTH-1:0] tx_period,
    input  logic [PERIOD_WIDTH-1:0] rx_period,
`ifdef EMU_EDGE_SCHED_RX_JITTER_EN
    input  logic signed [7:0]       rx_jitter,
`endif
    output logic                    cke_tx,
    output logic                    cke_rx_p,
    output logic                    cke_rx_n,
    output logic [TIME_WIDTH-1:0]   emu_time,
    output logic [TIME_WIDTH-1:0]   dt
);

    // Scheduler state (emu_time doubles as the registered output).
    logic [TIME_WIDTH-1:0] t_tx;
    logic [TIME_WIDTH-1:0] t_rxp;
    logic [TIME_WIDTH-1:0] t_rxn;
    logic                  rxn_pend;

    // Step datapath.
    logic [TIME_WIDTH-1:0] d_tx;
    logic [TIME_WIDTH-1:0] d_rxp;
    logic [TIME_WIDTH-1:0] d_rxn;
    logic [TIME_WIDTH-1:0] d_min;
    logic [TIME_WIDTH-1:0] t_fire;
    logic [TIME_WIDTH-1:0] tx_inc;
    logic [TIME_WIDTH-1:0] rx_inc;
    logic [TIME_WIDTH-1:0] rx_half;
    logic                  fire_tx;
    logic                  fire_rxp;
    logic                  fire_rxn;

`ifdef EMU_EDGE_SCHED_RX_JITTER_EN
    localparam int unsigned SUM_WIDTH = TIME_WIDTH + 1;
    // One extra bit so a negative period + jitter is visible as the sign.
    logic [SUM_WIDTH-1:0]  rx_sum;
`endif

    // -------------------------------------------------------------------------
    // Earliest-event selection and rescheduling increments
    // -------------------------------------------------------------------------
    always_comb begin
        // Distances from the current time; modular subtraction keeps the
        // ordering correct across wrap of the absolute time.
        d_tx  = t_tx  - emu_time;
        d_rxp = t_rxp - emu_time;
        d_rxn = t_rxn - emu_time;

        d_min = d_tx;
        if (d_rxp < d_min) begin
            d_min = d_rxp;
        end
        if (rxn_pend && (d_rxn < d_min)) begin
            d_min = d_rxn;
        end

        fire_tx  = (d_tx == d_min);
        fire_rxp = (d_rxp == d_min);
        fire_rxn = rxn_pend && (d_rxn == d_min);

        t_fire = emu_time + d_min;

        tx_inc = TIME_WIDTH'(tx_period);
        if (tx_period == '0) begin
            tx_inc = TIME_WIDTH'(1);
        end

`ifdef EMU_EDGE_SCHED_RX_JITTER_EN
        rx_sum = {1'b0, TIME_WIDTH'(rx_period)}
               + {{(SUM_WIDTH-8){rx_jitter[7]}}, rx_jitter};
        if (rx_sum[SUM_WIDTH-1] || (rx_sum[TIME_WIDTH-1:0] < TIME_WIDTH'(2))) begin
            rx_inc = TIME_WIDTH'(2);
        end else begin
            rx_inc = rx_sum[TIME_WIDTH-1:0];
        end
`else
        rx_inc = TIME_WIDTH'(rx_period);
        if (rx_inc < TIME_WIDTH'(2)) begin
            rx_inc = TIME_WIDTH'(2);
        end
`endif

        // Falling edge sits at half the rising-edge period (rounded down);
        // with rx_inc >= 2 it always lands strictly before the next rising edge.
        rx_half = rx_inc >> 1;
    end

    // -------------------------------------------------------------------------
    // State and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_sys) begin
        if (rst) begin
            emu_time <= '0;
            dt       <= '0;
            t_tx     <= '0;
            t_rxp    <= '0;
            t_rxn    <= '0;
            rxn_pend <= 1'b0;
            cke_tx   <= 1'b0;
            cke_rx_p <= 1'b0;
            cke_rx_n <= 1'b0;
        end else if (run) begin
            emu_time <= t_fire;
            dt       <= d_min;
            cke_tx   <= fire_tx;
            cke_rx_p <= fire_rxp;
            cke_rx_n <= fire_rxn;

            if (fire_tx) begin
                t_tx <= t_fire + tx_inc;
            end

            // A rising edge always arms a new falling edge, even if a falling
            // edge fired in the same step.
            if (fire_rxp) begin
                t_rxp    <= t_fire + rx_inc;
                t_rxn    <= t_fire + rx_half;
                rxn_pend <= 1'b1;
            end else if (fire_rxn) begin
                rxn_pend <= 1'b0;
            end
        end else begin
            cke_tx   <= 1'b0;
            cke_rx_p <= 1'b0;
            cke_rx_n <= 1'b0;
            dt       <= '0;
        end
    end

endmodule

// File: tb/tb_emu_edge_sched.sv
// -----------------------------------------------------------------------------
// tb_emu_edge_sched
//
// Directed bench for emu_edge_sched. Two instances: the default 32/24-bit
// build and an 8/6-bit build for time wrap-around. Expected events are pushed
// to a queue when a step is driven (either literal sequences or an
// absolute-time reference model) and popped when the DUT presents the step.
// -----------------------------------------------------------------------------
module tb_emu_edge_sched;

    typedef struct packed {
        logic        tx;
        logic        rxp;
        logic        rxn;
        logic [31:0] t;
        logic [31:0] dt;
    } exp_t;

    logic        clk_sys = 1'b0;
    logic        rst     = 1'b1;
    logic        run     = 1'b0;
    logic        run8    = 1'b0;
    logic [23:0] tx_period = '0;
    logic [23:0] rx_period = '0;
    logic [5:0]  tx8 = '0;
    logic [5:0]  rx8 = '0;
    logic signed [7:0] rx_jitter = '0;

    logic        cke_tx, cke_rx_p, cke_rx_n;
    logic [31:0] emu_time, dt;
    logic        cke8_tx, cke8_rx_p, cke8_rx_n;
    logic [7:0]  emu_time8, dt8;

    always #5 clk_sys = ~clk_sys;

    emu_edge_sched #(.TIME_WIDTH(32), .PERIOD_WIDTH(24)) dut (
        .clk_sys   (clk_sys),
        .rst       (rst),
        .run       (run),
        .tx_period (tx_period),
        .rx_period (rx_period),
`ifdef EMU_EDGE_SCHED_RX_JITTER_EN
        .rx_jitter (rx_jitter),
`endif
        .cke_tx    (cke_tx),
        .cke_rx_p  (cke_rx_p),
        .cke_rx_n  (cke_rx_n),
        .emu_time  (emu_time),
        .dt        (dt)
    );

    emu_edge_sched #(.TIME_WIDTH(8), .PERIOD_WIDTH(6)) dut8 (
        .clk_sys   (clk_sys),
        .rst       (rst),
        .run       (run8),
        .tx_period (tx8),
        .rx_period (rx8),
`ifdef EMU_EDGE_SCHED_RX_JITTER_EN
        .rx_jitter (rx_jitter),
`endif
        .cke_tx    (cke8_tx),
        .cke_rx_p  (cke8_rx_p),
        .cke_rx_n  (cke8_rx_n),
        .emu_time  (emu_time8),
        .dt        (dt8)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    exp_t        q[$];
    bit          sel8 = 1'b0;
    logic [31:0] last_t = '0;
    string       scen = "init";

    // Reference model: unbounded absolute times, reduced modulo width on push.
    longint m_time, m_tx, m_rxp, m_rxn;
    bit     m_pend;

    task automatic model_reset();
        m_time = 0; m_tx = 0; m_rxp = 0; m_rxn = 0; m_pend = 1'b0;
    endtask

    task automatic push_model();
        exp_t   e;
        longint tmin;
        longint mask;
        int     p;
        mask = sel8 ? 64'hFF : 64'hFFFF_FFFF;
        tmin = m_tx;
        if (m_rxp < tmin) tmin = m_rxp;
        if (m_pend && m_rxn < tmin) tmin = m_rxn;
        e.tx  = (m_tx == tmin);
        e.rxp = (m_rxp == tmin);
        e.rxn = m_pend && (m_rxn == tmin);
        e.t   = 32'((tmin & mask));
        e.dt  = 32'(((tmin - m_time) & mask));
        m_time = tmin;
        if (e.tx) begin
            p = sel8 ? int'(tx8) : int'(tx_period);
            if (p < 1) p = 1;
            m_tx = tmin + p;
        end
        if (e.rxp) begin
            p = (sel8 ? int'(rx8) : int'(rx_period)) + int'(rx_jitter);
            if (p < 2) p = 2;
            m_rxp  = tmin + p;
            m_rxn  = tmin + p / 2;
            m_pend = 1'b1;
        end else if (e.rxn) begin
            m_pend = 1'b0;
        end
        q.push_back(e);
    endtask

    task automatic push_lit(input logic tx, input logic rxp, input logic rxn,
                            input int t, input int d);
        exp_t e;
        e.tx = tx; e.rxp = rxp; e.rxn = rxn;
        e.t  = 32'(t);
        e.dt = 32'(d);
        q.push_back(e);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s/%s: observed %0d expected %0d", scen, tag, obs, exp_v);
        end
    endtask

    function automatic logic [2:0] obs_cke();
        return sel8 ? {cke8_tx, cke8_rx_p, cke8_rx_n} : {cke_tx, cke_rx_p, cke_rx_n};
    endfunction

    function automatic logic [31:0] obs_time();
        return sel8 ? {24'b0, emu_time8} : emu_time;
    endfunction

    function automatic logic [31:0] obs_dt();
        return sel8 ? {24'b0, dt8} : dt;
    endfunction

    // One step with run held high; the expected entry was pushed beforehand.
    task automatic step();
        exp_t e;
        if (sel8) run8 = 1'b1; else run = 1'b1;
        @(posedge clk_sys);
        #1;
        if (q.size() == 0) begin
            n_cmp++;
            n_err++;
            $error("FAIL %s/scoreboard: observed empty queue expected an entry", scen);
        end else begin
            e = q.pop_front();
            check("cke{tx,rxp,rxn}", {29'b0, obs_cke()}, {29'b0, e.tx, e.rxp, e.rxn});
            check("emu_time", obs_time(), e.t);
            check("dt", obs_dt(), e.dt);
            last_t = e.t;
        end
    endtask

    task automatic idle(input int n);
        run  = 1'b0;
        run8 = 1'b0;
        repeat (n) begin
            @(posedge clk_sys);
            #1;
            check("idle_cke", {29'b0, obs_cke()}, 32'd0);
            check("idle_dt", obs_dt(), 32'd0);
            check("idle_time", obs_time(), last_t);
        end
    endtask

    task automatic reset_dut(input logic run_hi);
        rst = 1'b1;
        if (sel8) run8 = run_hi; else run = run_hi;
        @(posedge clk_sys);
        #1;
        check("rst_cke", {29'b0, obs_cke()}, 32'd0);
        check("rst_time", obs_time(), 32'd0);
        check("rst_dt", obs_dt(), 32'd0);
        rst  = 1'b0;
        run  = 1'b0;
        run8 = 1'b0;
        model_reset();
        last_t = '0;
        q.delete();
    endtask

    initial begin
        model_reset();

        // Reset state and idle hold after reset
        scen = "reset";
        sel8 = 1'b0;
        repeat (2) @(posedge clk_sys);
        #1;
        reset_dut(1'b0);
        idle(1);

        // Equal periods: tx and rx_p coincide every 10, rx_n in between
        scen = "p10_10";
        tx_period = 24'd10; rx_period = 24'd10;
        push_lit(1, 1, 0,  0, 0); step();
        push_lit(0, 0, 1,  5, 5); step();
        push_lit(1, 1, 0, 10, 5); step();
        push_lit(0, 0, 1, 15, 5); step();
        push_lit(1, 1, 0, 20, 5); step();

        // Interleaved periods 7 / 10
        scen = "p7_10";
        reset_dut(1'b0);
        tx_period = 24'd7; rx_period = 24'd10;
        push_lit(1, 1, 0,  0, 0); step();
        push_lit(0, 0, 1,  5, 5); step();
        push_lit(1, 0, 0,  7, 2); step();
        push_lit(0, 1, 0, 10, 3); step();
        push_lit(1, 0, 0, 14, 4); step();
        push_lit(0, 0, 1, 15, 1); step();
        push_lit(0, 1, 0, 20, 5); step();
        push_lit(1, 0, 0, 21, 1); step();

        // Pause after the event at 7, resume at 10
        scen = "pause";
        reset_dut(1'b0);
        push_lit(1, 1, 0, 0, 0); step();
        push_lit(0, 0, 1, 5, 5); step();
        push_lit(1, 0, 0, 7, 2); step();
        idle(4);
        push_lit(0, 1, 0, 10, 3); step();

        // rx_period change between events takes effect at the next rx_p firing
        scen = "rx_change";
        reset_dut(1'b0);
        tx_period = 24'd7; rx_period = 24'd10;
        repeat (4) begin push_model(); step(); end
        rx_period = 24'd20;
        repeat (8) begin push_model(); step(); end

        // Reset while running: next cycle all zero, then restart at time 0
        scen = "mid_reset";
        reset_dut(1'b1);
        push_model(); step();
        push_model(); step();

        // Degenerate periods clamp to tx 1 / rx 2
        scen = "clamp";
        reset_dut(1'b0);
        tx_period = 24'd0; rx_period = 24'd1;
        repeat (6) begin push_model(); step(); end
        rx_period = 24'd0;
        repeat (4) begin push_model(); step(); end

`ifdef EMU_EDGE_SCHED_RX_JITTER_EN
        // Negative jitter shortens the rx period, large jitter clamps to 2
        scen = "jitter";
        reset_dut(1'b0);
        tx_period = 24'd100; rx_period = 24'd10; rx_jitter = -8'sd3;
        repeat (4) begin push_model(); step(); end
        rx_jitter = -8'sd10;
        repeat (6) begin push_model(); step(); end
        rx_jitter = 8'sd0;
`endif

        // 8-bit time wraps; ordering must stay correct across the wrap
        scen = "wrap8";
        sel8 = 1'b1;
        reset_dut(1'b0);
        tx8 = 6'd50; rx8 = 6'd60;
        repeat (24) begin push_model(); step(); end
        idle(2);
        push_model(); step();
        sel8 = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Hard stop in case the sequence above ever stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
